// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: VGA (A, high priority) vs OLED (B) with owner-tagged return path.
// Optional macro FB_ARB_STARVE_GUARD_EN lets B win one cycle after MAX_WAIT cycles of waiting.
module fb_read_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 15
) (
   input  logic              wclk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [DATA_W-1:0] fb_dout,
   output logic [7:0]        b_wait_max
);

`ifdef FB_ARB_STARVE_GUARD_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   // Tag encoding {valid, owner}: owner 0 = A, 1 = B.
   localparam logic [1:0] TAG_NONE = 2'b00;
   localparam logic [1:0] TAG_A    = 2'b10;
   localparam logic [1:0] TAG_B    = 2'b11;

   logic                   guard_fire;
   logic [1:0]             tag_new;
   logic [RD_LAT-1:0][1:0] tag_q, tag_d;
   logic [ADDR_W-1:0]      fb_addr_q, fb_addr_d;
   logic [7:0]             wait_q, wait_d;
   logic [7:0]             wait_max_q, wait_max_d;
   logic                   a_rvalid_q, a_rvalid_d;
   logic                   b_rvalid_q, b_rvalid_d;
   logic [DATA_W-1:0]      a_hold_q, a_hold_d;
   logic [DATA_W-1:0]      b_hold_q, b_hold_d;

   // Grant selection: strict A priority unless the starvation guard fires for B.
   always_comb begin
      guard_fire = 1'b0;
      if (GUARD_EN && b_req && (wait_q >= WAIT_LIMIT)) begin
         guard_fire = 1'b1;
      end else begin
         guard_fire = 1'b0;
      end
      a_gnt = !rst && a_req && !guard_fire;
      b_gnt = !rst && b_req && (!a_req || guard_fire);
   end

   // Next-state for issue address, tag pipeline, wait tracking and return steering.
   always_comb begin
      fb_addr_d  = fb_addr_q;
      tag_new    = TAG_NONE;
      wait_d     = 8'd0;
      wait_max_d = wait_max_q;

      if (a_gnt) begin
         fb_addr_d = a_addr;
         tag_new   = TAG_A;
      end else if (b_gnt) begin
         fb_addr_d = b_addr;
         tag_new   = TAG_B;
      end else begin
         fb_addr_d = fb_addr_q;
         tag_new   = TAG_NONE;
      end

      tag_d[0] = tag_new;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      if (b_req && !b_gnt) begin
         wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      end else begin
         wait_d = 8'd0;
      end

      if (wait_d > wait_max_q) begin
         wait_max_d = wait_d;
      end else begin
         wait_max_d = wait_max_q;
      end

      // The rvalid flops are the final tag stage, aligned with fb_dout from the BRAM.
      a_rvalid_d = (tag_q[RD_LAT-1] == TAG_A);
      b_rvalid_d = (tag_q[RD_LAT-1] == TAG_B);

      if (a_rvalid_q) begin
         a_hold_d = fb_dout;
      end else begin
         a_hold_d = a_hold_q;
      end
      if (b_rvalid_q) begin
         b_hold_d = fb_dout;
      end else begin
         b_hold_d = b_hold_q;
      end
   end

   // State registers with synchronous reset; reset drops every in-flight tag.
   always_ff @(posedge wclk) begin
      if (rst) begin
         tag_q      <= {RD_LAT{TAG_NONE}};
         fb_addr_q  <= {ADDR_W{1'b0}};
         wait_q     <= 8'd0;
         wait_max_q <= 8'd0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_hold_q   <= {DATA_W{1'b0}};
         b_hold_q   <= {DATA_W{1'b0}};
      end else begin
         tag_q      <= tag_d;
         fb_addr_q  <= fb_addr_d;
         wait_q     <= wait_d;
         wait_max_q <= wait_max_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_hold_q   <= a_hold_d;
         b_hold_q   <= b_hold_d;
      end
   end

   // Returned word bypasses the hold register so data lines up with rvalid.
   assign a_rdata    = a_rvalid_q ? fb_dout : a_hold_q;
   assign b_rdata    = b_rvalid_q ? fb_dout : b_hold_q;
   assign a_rvalid   = a_rvalid_q;
   assign b_rvalid   = b_rvalid_q;
   assign fb_addr    = fb_addr_q;
   assign b_wait_max = wait_max_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Scoreboard bench for fb_read_arbiter: one stimulus stream drives an RD_LAT=1 and an RD_LAT=3 instance.
// Starvation expectations follow FB_ARB_STARVE_GUARD_EN when the bench is built with it.
module tb_fb_read_arbiter;
   localparam int AW = 13;
   localparam int DW = 16;

   logic wclk = 1'b0;
   always #5 wclk = ~wclk;

   logic          rst, a_req, b_req;
   logic [AW-1:0] a_addr, b_addr;

   logic          a_gnt1, b_gnt1, a_rv1, b_rv1;
   logic [DW-1:0] a_rd1, b_rd1, dout1;
   logic [AW-1:0] fb1;
   logic [7:0]    wmax1;
   logic          a_gnt3, b_gnt3, a_rv3, b_rv3;
   logic [DW-1:0] a_rd3, b_rd3, dout3;
   logic [AW-1:0] fb3;
   logic [7:0]    wmax3;

   fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_WAIT(15)) u_lat1 (
      .wclk(wclk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
      .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
      .fb_addr(fb1), .fb_dout(dout1), .b_wait_max(wmax1));

   fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_WAIT(15)) u_lat3 (
      .wclk(wclk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt3), .a_rvalid(a_rv3), .a_rdata(a_rd3),
      .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt3), .b_rvalid(b_rv3), .b_rdata(b_rd3),
      .fb_addr(fb3), .fb_dout(dout3), .b_wait_max(wmax3));

   // BRAM models: word at address x is x + 0x1000, RD_LAT cycles after fb_addr.
   logic [AW-1:0] p1;
   logic [AW-1:0] p3 [0:2];
   always @(posedge wclk) begin
      p1    <= fb1;
      p3[0] <= fb3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign dout1 = 16'h1000 + {3'b000, p1};
   assign dout3 = 16'h1000 + {3'b000, p3[2]};

   int cyc = 0;
   always @(posedge wclk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t qa1[$], qb1[$], qa3[$], qb3[$];
   exp_t ea1, eb1, ea3, eb3;
   logic [15:0] la1 = 16'h0, lb1 = 16'h0, la3 = 16'h0, lb3 = 16'h0;
   logic [AW-1:0] exp_fb = '0;
   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop expected beats whenever a DUT presents rvalid; otherwise rdata must hold.
   always @(negedge wclk) begin
      if (mon_en) begin
         chk("rv_excl_lat1", 32'(a_rv1 && b_rv1), 32'd0);
         chk("rv_excl_lat3", 32'(a_rv3 && b_rv3), 32'd0);
         if (a_rv1 === 1'b1) begin
            chk("a1_beat_expected", 32'(qa1.size() != 0), 32'd1);
            if (qa1.size() != 0) begin
               ea1 = qa1.pop_front();
               chk("a1_rdata", 32'(a_rd1), 32'(ea1.data));
               chk("a1_latency", 32'(cyc), 32'(ea1.due));
               la1 = ea1.data;
            end
         end else chk("a1_hold", 32'(a_rd1), 32'(la1));
         if (b_rv1 === 1'b1) begin
            chk("b1_beat_expected", 32'(qb1.size() != 0), 32'd1);
            if (qb1.size() != 0) begin
               eb1 = qb1.pop_front();
               chk("b1_rdata", 32'(b_rd1), 32'(eb1.data));
               chk("b1_latency", 32'(cyc), 32'(eb1.due));
               lb1 = eb1.data;
            end
         end else chk("b1_hold", 32'(b_rd1), 32'(lb1));
         if (a_rv3 === 1'b1) begin
            chk("a3_beat_expected", 32'(qa3.size() != 0), 32'd1);
            if (qa3.size() != 0) begin
               ea3 = qa3.pop_front();
               chk("a3_rdata", 32'(a_rd3), 32'(ea3.data));
               chk("a3_latency", 32'(cyc), 32'(ea3.due));
               la3 = ea3.data;
            end
         end else chk("a3_hold", 32'(a_rd3), 32'(la3));
         if (b_rv3 === 1'b1) begin
            chk("b3_beat_expected", 32'(qb3.size() != 0), 32'd1);
            if (qb3.size() != 0) begin
               eb3 = qb3.pop_front();
               chk("b3_rdata", 32'(b_rd3), 32'(eb3.data));
               chk("b3_latency", 32'(cyc), 32'(eb3.due));
               lb3 = eb3.data;
            end
         end else chk("b3_hold", 32'(b_rd3), 32'(lb3));
      end
   end

   // One clock cycle of stimulus with hand-computed grants; pushes expected beats on a grant.
   task automatic step(input logic ar, input logic [AW-1:0] aa, input logic br, input logic [AW-1:0] ba,
                       input logic r, input logic ega, input logic egb, input bit push);
      a_req = ar; a_addr = aa; b_req = br; b_addr = ba; rst = r;
      @(negedge wclk);
      if (mon_en) begin
         chk("a_gnt_lat1", 32'(a_gnt1), 32'(ega));
         chk("b_gnt_lat1", 32'(b_gnt1), 32'(egb));
         chk("a_gnt_lat3", 32'(a_gnt3), 32'(ega));
         chk("b_gnt_lat3", 32'(b_gnt3), 32'(egb));
         chk("fb_addr_lat1", 32'(fb1), 32'(exp_fb));
         chk("fb_addr_lat3", 32'(fb3), 32'(exp_fb));
      end
      if (ega) begin
         exp_fb = aa;
         if (push) begin
            qa1.push_back('{16'h1000 + {3'b000, aa}, cyc + 2});
            qa3.push_back('{16'h1000 + {3'b000, aa}, cyc + 4});
         end
      end else if (egb) begin
         exp_fb = ba;
         if (push) begin
            qb1.push_back('{16'h1000 + {3'b000, ba}, cyc + 2});
            qb3.push_back('{16'h1000 + {3'b000, ba}, cyc + 4});
         end
      end
      @(posedge wclk);
      #1;
      if (r) begin
         qa1.delete(); qb1.delete(); qa3.delete(); qb3.delete();
         la1 = 16'h0; lb1 = 16'h0; la3 = 16'h0; lb3 = 16'h0;
         exp_fb = '0;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      step(1'b0, 13'h0, 1'b0, 13'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic gb;
      rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
      @(posedge wclk); #1;
      do_reset();
      do_reset();
      mon_en = 1'b1;
      chk("wait_max_reset_lat1", 32'(wmax1), 32'd0);
      chk("wait_max_reset_lat3", 32'(wmax3), 32'd0);

      // A-only read of address 5.
      step(1'b1, 13'h005, 1'b0, 13'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(5);

      // Interleave: A pulses every other cycle, B held with its address until granted.
      for (int i = 0; i < 6; i++) begin
         step((i % 2) == 0, 13'h010 + 13'(i), 1'b1, 13'h100 + 13'(i / 2),
              1'b0, (i % 2) == 0, (i % 2) != 0, 1'b1);
      end
      idle(5);
      chk("wait_max_interleave_lat1", 32'(wmax1), 32'd1);

      // B waits 3 cycles then drops; counter must clear, so 2 later waits leave max at 3.
      for (int i = 0; i < 3; i++)
         step(1'b1, 13'h020 + 13'(i), 1'b1, 13'h200, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(1);
      for (int i = 0; i < 2; i++)
         step(1'b1, 13'h030 + 13'(i), 1'b1, 13'h201, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 13'h0, 1'b1, 13'h201, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(5);
      chk("wait_max_drop_lat1", 32'(wmax1), 32'd3);
      chk("wait_max_drop_lat3", 32'(wmax3), 32'd3);

      // Starvation: A held continuously with B requesting.
      do_reset();
      for (int i = 0; i < 300; i++) begin
`ifdef FB_ARB_STARVE_GUARD_EN
         gb = ((i % 16) == 15);
`else
         gb = 1'b0;
`endif
         step(1'b1, 13'(i), 1'b1, 13'h300, 1'b0, !gb, gb, 1'b1);
         if (i == 39) begin
`ifdef FB_ARB_STARVE_GUARD_EN
            chk("wait_max_40_lat1", 32'(wmax1), 32'd15);
`else
            chk("wait_max_40_lat1", 32'(wmax1), 32'd40);
`endif
         end
      end
`ifdef FB_ARB_STARVE_GUARD_EN
      chk("wait_max_300_lat1", 32'(wmax1), 32'd15);
      chk("wait_max_300_lat3", 32'(wmax3), 32'd15);
`else
      chk("wait_max_sat_lat1", 32'(wmax1), 32'd255);
      chk("wait_max_sat_lat3", 32'(wmax3), 32'd255);
`endif
      idle(6);

      // Reset mid-flight: the read granted just before reset must never return.
      do_reset();
      idle(1);
      step(1'b1, 13'h007, 1'b0, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      idle(1);
      chk("wait_max_midrst_lat1", 32'(wmax1), 32'd0);
      step(1'b1, 13'h009, 1'b0, 13'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(5);

      // Continuous B stream, addresses 0..9: no bubbles, in-order data on both latencies.
      for (int i = 0; i < 10; i++)
         step(1'b0, 13'h0, 1'b1, 13'(i), 1'b0, 1'b0, 1'b1, 1'b1);
      idle(6);

      chk("drain_a_lat1", 32'(qa1.size()), 32'd0);
      chk("drain_b_lat1", 32'(qb1.size()), 32'd0);
      chk("drain_a_lat3", 32'(qa3.size()), 32'd0);
      chk("drain_b_lat3", 32'(qb3.size()), 32'd0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
